// File: rtl/seq_detect_scheduler_if.sv
// ============================================================================
// Module      : seq_detect_scheduler_if
// Description : Request/grant, result and detector-side signal bundle for
//               seq_detect_scheduler. The slave modport is the scheduler's
//               view; the master modport is the view of its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_detect_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       gnt;
    logic             busy;
    logic             det_w;
    logic             det_step;
    logic             det_resetn;
    logic             det_z;
    logic             done;
    logic             done_id;
    logic [CNT_W-1:0] match_count;

    modport slave (
        input  req, data0, data1, det_z,
        output gnt, busy, det_w, det_step, det_resetn, done, done_id, match_count
    );

    modport master (
        output req, data0, data1, det_z,
        input  gnt, busy, det_w, det_step, det_resetn, done, done_id, match_count
    );
endinterface

`default_nettype wire

// File: rtl/seq_detect_scheduler.sv
// ============================================================================
// Module      : seq_detect_scheduler
// Description : Time-shares one serial sequence detector between two
//               requesters. Arbitrates round-robin, clears the detector,
//               shifts the granted word in LSB-first and reports how many
//               steps left the detector output high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    seq_detect_scheduler_if.slave bus
);

    localparam int                IDX_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SHIFT  = 3'd2,
        S_SETTLE = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_id;
    logic             r_last_served;
    logic             r_busy;
    logic             r_det_step;
    logic             r_det_resetn;
    logic             r_done;
    logic             r_done_id;
    logic [CNT_W-1:0] r_match_count;

    logic             w_take;
    logic             w_win_id;
    logic [1:0]       w_gnt;
    logic [CNT_W-1:0] w_count_next;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        w_win_id = 1'b0;
        unique case (bus.req)
            2'b01:   w_win_id = 1'b0;
            2'b10:   w_win_id = 1'b1;
            2'b11:   w_win_id = ~r_last_served;
            default: w_win_id = 1'b0;
        endcase
        w_take = (r_state == S_IDLE) && !reset && (bus.req != 2'b00);
        w_gnt  = w_take ? (w_win_id ? 2'b10 : 2'b01) : 2'b00;
    end

    // Saturating add of the detector output to the running match count.
    always_comb begin
        w_count_next = r_count;
        if (bus.det_z && (r_count != CNT_MAX)) begin
            w_count_next = r_count + CNT_W'(1);
        end
    end

    // Job sequencer: grant, clear detector, shift word, collect last response, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shreg       <= '0;
            r_idx         <= '0;
            r_count       <= '0;
            r_id          <= 1'b0;
            r_last_served <= 1'b1;
            r_busy        <= 1'b0;
            r_det_step    <= 1'b0;
            r_det_resetn  <= 1'b0;
            r_done        <= 1'b0;
            r_done_id     <= 1'b0;
            r_match_count <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_det_step   <= 1'b0;
                    r_det_resetn <= 1'b0;
                    if (w_take) begin
                        r_shreg       <= w_win_id ? bus.data1 : bus.data0;
                        r_id          <= w_win_id;
                        r_last_served <= w_win_id;
                        r_count       <= '0;
                        r_busy        <= 1'b1;
                        r_det_step    <= 1'b1;
                        r_state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_idx        <= '0;
                    r_det_step   <= 1'b1;
                    r_det_resetn <= 1'b1;
                    r_state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    // The first shift cycle still shows the response to the clear step.
                    r_shreg <= r_shreg >> 1;
                    if (r_idx != '0) begin
                        r_count <= w_count_next;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_det_step <= 1'b0;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_SETTLE: begin
                    r_count       <= w_count_next;
                    r_match_count <= w_count_next;
                    r_done_id     <= r_id;
                    r_done        <= 1'b1;
                    r_state       <= S_REPORT;
                end
                S_REPORT: begin
                    r_busy       <= 1'b0;
                    r_det_resetn <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_det_step <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.busy        = r_busy;
    assign bus.det_w       = r_shreg[0];
    assign bus.det_step    = r_det_step;
    assign bus.det_resetn  = r_det_resetn;
    assign bus.done        = r_done;
    assign bus.done_id     = r_done_id;
    assign bus.match_count = r_match_count;

endmodule

`default_nettype wire
